// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, optional wait states, two-cycle ERROR.
// Define AHB_SLV_ALIGN_CHK_EN to make misaligned half/word transfers return ERROR.
module ahb_lite_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  valid_q, write_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  accept, legal, misaligned, done;
    logic [ADDR_WIDTH-1:0] addr_masked;
    logic [NBYTES-1:0]     be;
    logic [IDX_W-1:0]      idx;
    logic                  unused_bits;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign accept = hsel && hready && htrans[1];

    always_comb begin
        misaligned = 1'b0;
`ifdef AHB_SLV_ALIGN_CHK_EN
        misaligned = (hsize == 3'b001 && haddr[0]) ||
                     (hsize == 3'b010 && haddr[1:0] != 2'b00);
`endif
    end

    assign legal = ({2'b00, haddr[ADDR_WIDTH-1:2]} < ADDR_WIDTH'(MEM_DEPTH)) &&
                   (hsize <= 3'b010) && !misaligned;

    // Low address bits are forced to natural alignment; only matters when the check is off.
    always_comb begin
        addr_masked = haddr;
        if (hsize == 3'b001) begin
            addr_masked[0] = 1'b0;
        end else if (hsize == 3'b010) begin
            addr_masked[1:0] = 2'b00;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        unique case (state_q)
            // ERR2 is the last error cycle but already accepts the next address phase.
            StIdle, StErr2: begin
                hresp   = (state_q == StErr2);
                state_d = StIdle;
                if (accept) begin
                    if (!legal) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES != 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            StWait: begin
                hreadyout = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = StErr2;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hready) begin
                valid_q <= accept && legal;
                if (accept) begin
                    addr_q  <= addr_masked;
                    write_q <= hwrite;
                    size_q  <= hsize;
                end
            end
        end
    end

    // A legal data phase completes in the first ready cycle back in IDLE.
    assign done = valid_q && (state_q == StIdle);
    assign idx  = addr_q[IDX_W+1:2];

    always_comb begin
        be = '0;
        unique case (size_q)
            3'b000: be[addr_q[1:0]] = 1'b1;
            3'b001: begin
                be[{addr_q[1], 1'b0}] = 1'b1;
                be[{addr_q[1], 1'b1}] = 1'b1;
            end
            default: be = '1;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hreset && done && write_q) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= hwdata[b*8 +: 8];
                end
            end
        end
    end

    assign hrdata = (done && !write_q) ? mem[idx] : '0;

    assign unused_bits = ^{hburst, htrans[0], addr_q[ADDR_WIDTH-1:IDX_W+2]};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench: vector tables run through a pipelined AHB driver with a response scoreboard,
// on three slave instances (0, 2 and 3 wait states) sharing one bus.
module tb_ahb_lite_sram_slave;

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        resp;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          waits;
        int          id;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b000;
    logic [2:0]  hburst = 3'b000;
    logic [31:0] hwdata = '0;
    logic        hready;

    logic [2:0]  ro, rs;
    logic [31:0] rd [3];
    int          sel = 0;
    int          cur_ws = 0;
    logic        hready_m, hresp_m;
    logic [31:0] hrdata_m;

    int n_chk = 0;
    int n_fail = 0;

    vec_t tab_a[$], tab_b[$], tab_c[$], vq[$];

    always #5 hclk = ~hclk;

    assign hready_m = ro[sel];
    assign hresp_m  = rs[sel];
    assign hrdata_m = rd[sel];
    assign hready   = hready_m;

    ahb_lite_sram_slave #(.WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro[0]), .hresp(rs[0]), .hrdata(rd[0])
    );
    ahb_lite_sram_slave #(.WAIT_STATES(2)) dut2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro[1]), .hresp(rs[1]), .hrdata(rd[1])
    );
    ahb_lite_sram_slave #(.WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro[2]), .hresp(rs[2]), .hrdata(rd[2])
    );

    function automatic vec_t mk(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic rsp, input logic [31:0] rdv);
        vec_t v;
        v.trans = tr; v.write = wr; v.size = sz; v.addr = a; v.wdata = wd;
        v.resp = rsp; v.rdata = rdv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bus idle at a negedge after the reset pulse.
    task automatic bus_reset(input string tag);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = '0;
        hreset = 1'b1;
        @(posedge hclk); @(negedge hclk);
        hreset = 1'b0;
        chk({tag, "_rst_ready"}, {31'd0, hready_m}, 32'd1);
        chk({tag, "_rst_resp"}, {31'd0, hresp_m}, 32'd0);
        chk({tag, "_rst_rdata"}, hrdata_m, 32'd0);
    endtask

    // Pipelined driver: address phase of vq[i] overlaps data phase of vq[i-1].
    task automatic run_vecs(input string tag);
        exp_t sb[$];
        exp_t e;
        int waits;
        logic [31:0] pend_wdata;
        pend_wdata = '0;
        for (int i = 0; i <= vq.size(); i++) begin
            if (i < vq.size()) begin
                hsel = 1'b1; htrans = vq[i].trans; hwrite = vq[i].write;
                hsize = vq[i].size; haddr = vq[i].addr;
            end else begin
                hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
            end
            hwdata = pend_wdata;
            waits = 0;
            while (hready_m !== 1'b1 && waits < 40) begin
                if (sb.size() > 0) begin
                    chk($sformatf("%s%0d_wait_resp", tag, sb[0].id), {31'd0, hresp_m},
                        {31'd0, sb[0].resp});
                    if (sb[0].resp) begin
                        chk($sformatf("%s%0d_err1_rdata", tag, sb[0].id), hrdata_m, 32'd0);
                    end
                end
                waits++;
                @(posedge hclk); @(negedge hclk);
            end
            if (waits >= 40) begin
                n_chk++; n_fail++;
                $display("FAIL %s%0d_timeout: hreadyout stuck low, expected high", tag, i);
                return;
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("%s%0d_waits", tag, e.id), waits, e.waits);
                chk($sformatf("%s%0d_resp", tag, e.id), {31'd0, hresp_m}, {31'd0, e.resp});
                chk($sformatf("%s%0d_rdata", tag, e.id), hrdata_m, e.rdata);
            end
            if (i < vq.size()) begin
                e.resp  = vq[i].resp;
                e.rdata = vq[i].rdata;
                e.id    = i;
                e.waits = (vq[i].trans[1] == 1'b0) ? 0 : (vq[i].resp ? 1 : cur_ws);
                sb.push_back(e);
                pend_wdata = vq[i].wdata;
            end
            @(posedge hclk); @(negedge hclk);
        end
    endtask

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;

    initial begin
        // Zero-wait slave: data, lanes, IDLE/BUSY, errors, alignment.
        tab_a.push_back(mk(NSQ, 1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0));
        tab_a.push_back(mk(NSQ, 0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF));
        tab_a.push_back(mk(NSQ, 1, 3'b010, 32'h20,  32'h0,        0, 32'h0));
        tab_a.push_back(mk(NSQ, 1, 3'b000, 32'h21,  32'h0000AA00, 0, 32'h0));
        tab_a.push_back(mk(NSQ, 1, 3'b001, 32'h22,  32'h12340000, 0, 32'h0));
        tab_a.push_back(mk(NSQ, 0, 3'b010, 32'h20,  32'h0,        0, 32'h1234AA00));
        tab_a.push_back(mk(IDL, 1, 3'b010, 32'h10,  32'hFFFFFFFF, 0, 32'h0));
        tab_a.push_back(mk(BSY, 1, 3'b010, 32'h10,  32'hFFFFFFFF, 0, 32'h0));
        tab_a.push_back(mk(NSQ, 0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF));
        tab_a.push_back(mk(NSQ, 1, 3'b010, 32'h0,   32'h11111111, 0, 32'h0));
        tab_a.push_back(mk(NSQ, 1, 3'b010, 32'h400, 32'h55555555, 1, 32'h0));
        tab_a.push_back(mk(NSQ, 0, 3'b010, 32'h0,   32'h0,        0, 32'h11111111));
        tab_a.push_back(mk(NSQ, 0, 3'b011, 32'h10,  32'h0,        1, 32'h0));
        tab_a.push_back(mk(NSQ, 0, 3'b010, 32'h400, 32'h0,        1, 32'h0));
        tab_a.push_back(mk(SEQ, 0, 3'b010, 32'h20,  32'h0,        0, 32'h1234AA00));
`ifdef AHB_SLV_ALIGN_CHK_EN
        tab_a.push_back(mk(NSQ, 1, 3'b010, 32'h13,  32'hCAFEF00D, 1, 32'h0));
        tab_a.push_back(mk(NSQ, 0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF));
`else
        tab_a.push_back(mk(NSQ, 1, 3'b010, 32'h13,  32'hCAFEF00D, 0, 32'h0));
        tab_a.push_back(mk(NSQ, 0, 3'b010, 32'h10,  32'h0,        0, 32'hCAFEF00D));
`endif
        // Three-wait slave: pipelined address held until completion, error stays two cycles.
        tab_b.push_back(mk(NSQ, 1, 3'b010, 32'h40,  32'hA5A5A5A5, 0, 32'h0));
        tab_b.push_back(mk(NSQ, 0, 3'b010, 32'h40,  32'h0,        0, 32'hA5A5A5A5));
        tab_b.push_back(mk(NSQ, 1, 3'b010, 32'h400, 32'h0,        1, 32'h0));
        tab_b.push_back(mk(NSQ, 1, 3'b000, 32'h42,  32'h00770000, 0, 32'h0));
        tab_b.push_back(mk(NSQ, 0, 3'b010, 32'h40,  32'h0,        0, 32'hA577A5A5));
        // Two-wait slave: word preset before the aborted write.
        tab_c.push_back(mk(NSQ, 1, 3'b010, 32'h30,  32'h0,        0, 32'h0));

        @(negedge hclk);
        sel = 0; cur_ws = 0;
        bus_reset("a");
        vq = tab_a;
        run_vecs("a");

        sel = 2; cur_ws = 3;
        bus_reset("b");
        vq = tab_b;
        run_vecs("b");

        sel = 1; cur_ws = 2;
        bus_reset("c");
        vq = tab_c;
        run_vecs("c");
        // Reset in the middle of a waited write must abort it.
        hsel = 1'b1; htrans = NSQ; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h30;
        @(posedge hclk); @(negedge hclk);
        hsel = 1'b0; htrans = IDL; hwrite = 1'b0; hwdata = 32'h77777777;
        chk("c_midwait_ready", {31'd0, hready_m}, 32'd0);
        #2 hreset = 1'b1;
        #1;
        chk("c_abort_ready", {31'd0, hready_m}, 32'd1);
        chk("c_abort_resp", {31'd0, hresp_m}, 32'd0);
        chk("c_abort_rdata", hrdata_m, 32'd0);
        @(posedge hclk); @(negedge hclk);
        hreset = 1'b0;
        vq.delete();
        vq.push_back(mk(NSQ, 0, 3'b010, 32'h30, 32'h0, 0, 32'h0));
        run_vecs("d");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite memory slave; the DUT that the AHB verification environment's driver stimulates and its monitor observes.
- Accepts pipelined address/data-phase transfers into a word-organised SRAM array.
- Supports configurable wait states, byte/halfword/word writes, and the two-cycle ERROR response for illegal accesses.

Parameters:
- ADDR_WIDTH, 32, width of haddr.
- DATA_WIDTH, 32, width of hwdata/hrdata; fixed byte lanes = DATA_WIDTH/8.
- MEM_DEPTH, 256, number of DATA_WIDTH words; legal byte addresses 0 .. MEM_DEPTH*4-1.
- WAIT_STATES, 0, extra hreadyout-low cycles inserted in every OKAY data phase (0..15).

Ports:
- hclk  in  1  system clock, all state on rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select (address phase).
- haddr  in  ADDR_WIDTH  byte address (address phase).
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 write, 0 read.
- hsize  in  3  000 byte, 001 half, 010 word; others illegal.
- hburst  in  3  burst type; informational only, not decoded.
- hwdata  in  DATA_WIDTH  write data (data phase).
- hready  in  1  bus-level ready; address phase is accepted only when high.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  DATA_WIDTH  read data (data phase).

Behaviour:
- Reset (async assert, sync deassert honoured by hclk): hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, registered address-phase fields cleared.
- Memory contents are not reset.
- Address-phase accept: when hsel && hready && htrans[1] all high, register haddr, hwrite, hsize and a valid flag.
- IDLE/BUSY or hsel=0 with hready=1: the following data phase is zero-wait OKAY with no memory effect.
- Illegal access, detected at accept:
  - word index (haddr>>2) >= MEM_DEPTH, or
  - hsize > 010.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: legal accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - IDLE: legal accept with WAIT_STATES=0 -> stays IDLE; transfer completes next cycle.
  - IDLE: illegal accept -> ERR1.
  - WAIT: hreadyout=0, hresp=0; counter decrements each cycle; at 0 -> IDLE with hreadyout=1 (completion cycle).
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1 -> IDLE.
- Erroring transfers never write memory, and hrdata=0 during them.
- New address phases are not accepted while hreadyout=0, because hready is low bus-wide.
- Pipelining: an accept in ERR2 or in a completion cycle is legal and starts the next transfer back-to-back.
- Write: memory updates on the rising edge that ends the write data phase (hreadyout=1). Byte lanes come from the registered haddr[1:0] and hsize, little-endian:
  - byte: lane haddr[1:0].
  - half: lanes {haddr[1],0} and +1.
  - word: all lanes.
- Read: hrdata = full word mem[index] during the read data phase; 0 otherwise. Valid only when hreadyout=1.
- Read immediately after a write to the same word returns the new data, since the write commits before the read data phase.
- Reset asserted mid-transfer aborts it: no write occurs and outputs return to reset values immediately.

Optional Feature:
- Macro: AHB_SLV_ALIGN_CHK_EN.
- Defined: misaligned transfers get the ERR1/ERR2 response with no memory effect:
  - hsize=001 with haddr[0]=1, or
  - hsize=010 with haddr[1:0]!=0.
- Undefined: misaligned low address bits are masked to the natural alignment (half: haddr[0]=0; word: haddr[1:0]=0) and the transfer completes OKAY.

Test Plan:
- Reset: assert hreset mid-WAIT with WAIT_STATES=2 -> hreadyout=1, hresp=0, hrdata=0 in the same cycle; a later read of that word shows no write occurred.
- Word write/read, WAIT_STATES=0: NONSEQ write 0xDEADBEEF to 0x10, then back-to-back NONSEQ read of 0x10 -> hrdata=0xDEADBEEF in the read data phase; hreadyout never low.
- Byte/half lanes: write word 0x00000000 to 0x20, byte 0xAA to 0x21, half 0x1234 to 0x22 -> word read of 0x20 returns 0x1234AA00.
- Wait states, WAIT_STATES=3: single read -> exactly 3 cycles hreadyout=0, then data with hreadyout=1; the next pipelined address phase is held until completion.
- Error: word write to 0x400 (index 256, MEM_DEPTH=256) -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); memory unchanged. With AHB_SLV_ALIGN_CHK_EN, word access to 0x13 -> same ERROR; without it, access maps to 0x10 with OKAY.
- IDLE/BUSY: htrans=00 and 01 with hsel=1 to 0x10 carrying hwdata=0xFFFFFFFF -> OKAY zero-wait; 0x10 still reads its previous value.
